// File: rtl/ram_fetch_unit.sv
// Sequential byte-fetch engine: reads the word RAM in order, buffers bytes with their addresses, and
// streams them over valid/ready. Define FETCH_WRAP_EN to wrap at the top of memory instead of halting.
module ram_fetch_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       JMP,
    input  logic [ADDR_W-1:0]          JMP_ADDR,
    output logic [ADDR_W-1:0]          RA,
    output logic                       RE,
    input  logic [DATA_W-1:0]          Q_IN,
    output logic [DATA_W-1:0]          OUT_DATA,
    output logic [ADDR_W-1:0]          OUT_ADDR,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       HALT
);

    // state | meaning
    // IDLE  | EN low, no reads issued, FIFO still drains
    // FETCH | EN high, issuing one read per cycle while there is room
    // STOP  | halted after reading the top address, left only by JMP
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic              run, pop, issue, top_stop;

    // Fetch permission is combinational on EN so the first read goes out in the cycle EN rises;
    // RST gates it so the read port goes quiet the moment reset is applied.
    assign run       = EN & (state != ST_STOP) & ~RST;
    assign OUT_VALID = (level != '0) & ~JMP;
    assign pop       = OUT_VALID & OUT_READY;
    assign issue     = run & ~JMP & ((level < LVL_W'(DEPTH)) | pop);

    assign RA       = pc;
    assign RE       = issue;
    assign LEVEL    = level;
    assign OUT_DATA = fifo_data[rd_ptr];
    assign OUT_ADDR = fifo_addr[rd_ptr];

`ifdef FETCH_WRAP_EN
    assign top_stop = 1'b0;
    assign HALT     = 1'b0;
`else
    assign top_stop = issue & (&pc);
    assign HALT     = (state == ST_STOP);
`endif

    always_comb begin
        state_nxt = state;
        if (JMP)
            state_nxt = EN ? ST_FETCH : ST_IDLE;
        else if (top_stop)
            state_nxt = ST_STOP;
        else if (state != ST_STOP)
            state_nxt = EN ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            pc     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state <= state_nxt;
            if (JMP) begin
                pc     <= JMP_ADDR;
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (issue) begin
                    pc     <= pc + ADDR_W'(1);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({issue, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Payload storage needs no reset; entries are only observed once LEVEL covers them.
    always_ff @(posedge CLK) begin
        if (issue) begin
            fifo_data[wr_ptr] <= Q_IN;
            fifo_addr[wr_ptr] <= pc;
        end
    end

endmodule

// File: tb/tb_ram_fetch_unit.sv
// Directed bench for ram_fetch_unit: stream, backpressure, jump flush, top of memory, async reset.
// Follows FETCH_WRAP_EN the same way as the design.
module tb_ram_fetch_unit;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       JMP;
    logic [9:0] JMP_ADDR;
    logic [9:0] RA;
    logic       RE;
    logic [7:0] Q_IN;
    logic [7:0] OUT_DATA;
    logic [9:0] OUT_ADDR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [2:0] LEVEL;
    logic       HALT;

    logic [7:0] ram [1024];
    int checks;
    int failures;

    ram_fetch_unit #(.ADDR_W(10), .DATA_W(8), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .JMP       (JMP),
        .JMP_ADDR  (JMP_ADDR),
        .RA        (RA),
        .RE        (RE),
        .Q_IN      (Q_IN),
        .OUT_DATA  (OUT_DATA),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .LEVEL     (LEVEL),
        .HALT      (HALT)
    );

    assign Q_IN = ram[RA];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM image: byte at address a is (a + 0x10) mod 256, so RAM[0..5] = 0x10..0x15.
    function automatic logic [7:0] exp_byte(input int a);
        return 8'((a + 16) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) ram[i] = exp_byte(i);
        RST = 1'b1; EN = 1'b0; JMP = 1'b0; JMP_ADDR = '0; OUT_READY = 1'b0;

        #12;
        chk("rst_level", LEVEL, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_re", RE, 0);
        chk("rst_halt", HALT, 0);
        chk("rst_ra", RA, 0);

        // stream from address 0, one byte per cycle
        RST = 1'b0; EN = 1'b1; OUT_READY = 1'b1;
        #1;
        chk("first_re", RE, 1);
        chk("first_ra", RA, 0);
        chk("first_novalid", OUT_VALID, 0);
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            chk("stream_valid", OUT_VALID, 1);
            chk("stream_data", OUT_DATA, exp_byte(i));
            chk("stream_addr", OUT_ADDR, i);
            chk("stream_re", RE, 1);
        end

        // backpressure after restarting at 0
        JMP = 1'b1; JMP_ADDR = 10'd0;
        #1;
        chk("jmp0_novalid", OUT_VALID, 0);
        chk("jmp0_re", RE, 0);
        next_cyc();
        JMP = 1'b0; OUT_READY = 1'b0;
        chk("jmp0_level", LEVEL, 0);
        for (int k = 1; k <= 8; k++) begin
            next_cyc();
            chk("bp_level", LEVEL, (k < 4) ? k : 4);
        end
        chk("bp_full_re", RE, 0);
        chk("bp_head", OUT_ADDR, 0);
        OUT_READY = 1'b1;
        #1;
        chk("rel_re", RE, 1);
        chk("rel_ra", RA, 4);
        chk("rel_head", OUT_ADDR, 0);
        for (int k = 1; k <= 5; k++) begin
            next_cyc();
            chk("rel_addr", OUT_ADDR, k);
            chk("rel_data", OUT_DATA, exp_byte(k));
            chk("rel_level", LEVEL, 4);
        end

        // drain one with EN low to reach LEVEL=3
        EN = 1'b0;
        #1;
        chk("enoff_re", RE, 0);
        next_cyc();
        chk("enoff_level", LEVEL, 3);
        chk("enoff_head", OUT_ADDR, 6);

        // jump flush to 0x200
        JMP = 1'b1; JMP_ADDR = 10'h200; EN = 1'b1;
        #1;
        chk("flush_novalid", OUT_VALID, 0);
        chk("flush_re", RE, 0);
        next_cyc();
        JMP = 1'b0;
        #1;
        chk("flush_level", LEVEL, 0);
        chk("flush_valid_low", OUT_VALID, 0);
        chk("flush_re_tgt", RE, 1);
        chk("flush_ra_tgt", RA, 10'h200);
        next_cyc();
        chk("flush_valid", OUT_VALID, 1);
        chk("flush_addr", OUT_ADDR, 10'h200);
        chk("flush_data", OUT_DATA, 8'h10);

        // top of memory
        JMP = 1'b1; JMP_ADDR = 10'h3FE;
        next_cyc();
        JMP = 1'b0;
        next_cyc();
        chk("top_addr_3fe", OUT_ADDR, 10'h3FE);
        chk("top_data_3fe", OUT_DATA, 8'h0E);
        chk("top_ra_3ff", RA, 10'h3FF);
        chk("top_re_3ff", RE, 1);
        next_cyc();
        chk("top_addr_3ff", OUT_ADDR, 10'h3FF);
        chk("top_data_3ff", OUT_DATA, 8'h0F);
`ifdef FETCH_WRAP_EN
        chk("wrap_halt", HALT, 0);
        chk("wrap_re", RE, 1);
        chk("wrap_ra", RA, 0);
        next_cyc();
        chk("wrap_addr", OUT_ADDR, 0);
        chk("wrap_data", OUT_DATA, 8'h10);
        chk("wrap_halt2", HALT, 0);
`else
        chk("stop_halt", HALT, 1);
        chk("stop_re", RE, 0);
        chk("stop_ra", RA, 0);
        next_cyc();
        chk("stop_drained", OUT_VALID, 0);
        chk("stop_halt_hold", HALT, 1);
        chk("stop_re_hold", RE, 0);
        JMP = 1'b1; JMP_ADDR = 10'd0;
        #1;
        chk("stop_halt_jmpcyc", HALT, 1);
        next_cyc();
        JMP = 1'b0;
        #1;
        chk("stop_halt_clear", HALT, 0);
        chk("stop_re_resume", RE, 1);
`endif

        // asynchronous reset with two bytes buffered
        JMP = 1'b1; JMP_ADDR = 10'h010; OUT_READY = 1'b0;
        next_cyc();
        JMP = 1'b0;
        next_cyc();
        next_cyc();
        chk("pre_rst_level", LEVEL, 2);
        #2 RST = 1'b1;
        #1;
        chk("arst_valid", OUT_VALID, 0);
        chk("arst_re", RE, 0);
        chk("arst_level", LEVEL, 0);
        #1 RST = 1'b0;
        #1;
        chk("post_rst_re", RE, 1);
        chk("post_rst_ra", RA, 0);
        OUT_READY = 1'b1;
        next_cyc();
        chk("post_rst_valid", OUT_VALID, 1);
        chk("post_rst_addr", OUT_ADDR, 0);
        chk("post_rst_data", OUT_DATA, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fetch_unit.md
# ram_fetch_unit

Sequential byte-fetch engine sitting directly downstream of the 1024×8 word RAM. It drives the RAM read port (read address plus read enable), captures each returned byte into a small prefetch FIFO tagged with its address, and presents the stream to the decode stage over a valid/ready handshake. It also supports redirects (jumps), which flush the prefetch buffer, and has a compile-time choice between wrapping the fetch address and halting at the top of memory.

## Interface
- `ADDR_W`, default 10: RAM address width (1024 words).
- `DATA_W`, default 8: RAM word width.
- `DEPTH`, default 4: prefetch FIFO entries; must be a power of two and at least 2.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `EN`, in, 1: fetch enable. When low, no new RAM reads are issued; the FIFO still drains.
- `JMP`, in, 1: redirect request, one-cycle pulse or held.
- `JMP_ADDR`, in, ADDR_W: redirect target.
- `RA`, out, ADDR_W: RAM read address; always equals PC.
- `RE`, out, 1: RAM read enable; high exactly in issue cycles.
- `Q_IN`, in, DATA_W: RAM read data. It is combinational from `RA`, and valid in the same cycle.
- `OUT_DATA`, out, DATA_W: head-of-FIFO byte.
- `OUT_ADDR`, out, ADDR_W: address the head byte was fetched from.
- `OUT_VALID`, out, 1: head entry valid.
- `OUT_READY`, in, 1: consumer accepts the head.
- `LEVEL`, out, log2(DEPTH)+1: FIFO occupancy.
- `HALT`, out, 1: fetch stopped at the top of memory. This port exists only without the wrap macro; otherwise it is tied to 0.

## Operation
- State machine, three states:
  - IDLE: `EN`=0.
  - FETCH: `EN`=1, not halted.
  - STOP: halted at top of memory.
- State transitions:
  - IDLE→FETCH when `EN`=1.
  - FETCH→IDLE when `EN`=0.
  - FETCH→STOP after an issue at PC=2^ADDR_W−1, only without the wrap macro.
  - STOP→FETCH (or IDLE, depending on `EN`) only on `JMP`.
- Pop condition: pop = `OUT_VALID` & `OUT_READY`.
- Issue condition: issue = FETCH & !`JMP` & (`LEVEL` < DEPTH | pop). A read is therefore issued into a full FIFO when a pop happens in the same cycle.
- On an issue, at the clock edge:
  - push {PC, `Q_IN`} onto the FIFO;
  - PC ← PC+1, modulo 2^ADDR_W.
- Simultaneous push and pop: `LEVEL` is unchanged; ordering is preserved.
- `JMP` has priority over everything else:
  - Combinationally: `OUT_VALID` is forced to 0, so no pop can occur, and `RE` is 0.
  - At the edge: FIFO cleared (`LEVEL` ← 0), PC ← `JMP_ADDR`, STOP state exited.
- `OUT_VALID` = (`LEVEL` ≠ 0) & !`JMP`.
- `OUT_DATA` and `OUT_ADDR` are driven from the head entry. They are don't-care when `OUT_VALID` is 0.
- Deasserting `EN` mid-stream: fetching stops immediately and buffered bytes remain poppable. Reasserting `EN` resumes at the current PC.

## Timing
- Reset values (asynchronous): PC=0, `LEVEL`=0, `OUT_VALID`=0, `RE`=0, `HALT`=0, state=IDLE. FIFO pointers are zeroed; FIFO data is don't-care.
- Reset mid-stream discards all buffered bytes with no partial pop.
- Fetch latency:
  - a byte issued at edge N is visible on `OUT_*` right after edge N;
  - it can be popped in cycle N+1.
- First-fetch latency: `EN` rises in cycle 0 → `RE`=1 in cycle 0 → `OUT_VALID`=1 after edge 0.
- Sustained throughput with `OUT_READY` held high: one byte per cycle.
- After a `JMP` at edge N:
  - the first read of `JMP_ADDR` is issued in cycle N+1;
  - `OUT_VALID` goes high after edge N+1.
- `RE` and `RA` are combinational from registered state and `JMP`/`EN`. There are no paths from `Q_IN` to `RE` or `RA`.

## Configuration
- Macro: `FETCH_WRAP_EN`.
- Defined: PC wraps from 1023 to 0 and fetching continues. STOP is unreachable and `HALT` is tied to 0.
- Undefined: the issue at 1023 moves the state machine to STOP.
  - `HALT` goes to 1 at that same edge and `RE` stays 0.
  - The FIFO still drains.
  - PC holds at 0 (wrapped) and is not used until the next `JMP`.
  - `HALT` clears at the edge where `JMP` is sampled.

## Test plan
- **Reset then stream:** RAM[0..5] = 0x10..0x15, `EN`=1, `OUT_READY`=1 → `OUT_DATA` sequence 0x10..0x15 with `OUT_ADDR` 0..5, one byte per cycle. `RE` is high every cycle.
- **Backpressure:** hold `OUT_READY`=0 for 8 cycles → `LEVEL` saturates at 4 and `RE`=0 while full. Releasing `OUT_READY` delivers bytes for addresses 0..3, then 4 onward, with no loss or duplication.
- **Jump flush:** with `LEVEL`=3, pulse `JMP` with `JMP_ADDR`=0x200 → `OUT_VALID`=0 in the `JMP` cycle and `LEVEL`=0 after the edge. The next delivered byte is RAM[0x200] with `OUT_ADDR`=0x200.
- **Top of memory:**
  - `JMP` to 0x3FE.
  - Without `FETCH_WRAP_EN`: RAM[0x3FE] and RAM[0x3FF] are delivered, then `HALT`=1 and `RE` stays 0. A later `JMP` to 0 clears `HALT`.
  - With `FETCH_WRAP_EN`: 0x3FE, 0x3FF and 0x000 are delivered in sequence.
- **Asynchronous reset mid-stream:** assert `RST` between edges while `LEVEL`=2 → `OUT_VALID`=0 and `RE`=0 immediately. After release with `EN`=1, the stream restarts from address 0.
